// File: rtl/multi_switch_cleaner.sv
// multi_switch_cleaner
//   Multi-channel mechanical-switch cleaner. Each raw input is synchronised,
//   sampled on a shared prescaled tick and accepted only after STABLE_TICKS
//   consecutive equal samples. Accepted edges (per EDGE_MODE) and optional
//   auto-repeat while held high produce one-clock pulses on clean.
//
// Ports
//   clock   system clock, rising edge
//   reset   synchronous, active-high
//   raw     [CHANNELS] asynchronous raw switch levels
//   clean   [CHANNELS] one-cycle event pulses
//   level   [CHANNELS] debounced levels
//   enable  sample tick, one cycle every TICK_DIV cycles
//   busy    any channel currently confirming a change

module msc_channel #(
    parameter int STABLE_TICKS = 3,
    parameter int EDGE_MODE    = 0,
    parameter int REPEAT_TICKS = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic raw_s,
    output logic clean,
    output logic level,
    output logic busy
);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam int RW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
    // Comparing against terminal-1 before incrementing keeps counters from
    // ever holding a value past their terminal count.
    localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_TICKS - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
    localparam logic PULSE_RISE = (EDGE_MODE == 0) || (EDGE_MODE == 2);
    localparam logic PULSE_FALL = (EDGE_MODE == 1) || (EDGE_MODE == 2);

    typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] rep, rep_n;
    logic          pulse_n, level_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LOW;
            cnt   <= '0;
            rep   <= '0;
            clean <= 1'b0;
            level <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rep   <= rep_n;
            clean <= pulse_n;
            level <= level_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rep_n   = rep;
        pulse_n = 1'b0;
        level_n = level;
        if (tick) begin
            case (state)
                LOW: begin
                    rep_n = '0;
                    if (raw_s) begin
                        if (STABLE_TICKS == 1) begin
                            state_n = HIGH;
                            cnt_n   = '0;
                            level_n = 1'b1;
                            pulse_n = PULSE_RISE;
                        end else begin
                            state_n = RISE_WAIT;
                            cnt_n   = CW'(1);
                        end
                    end
                end
                RISE_WAIT: begin
                    rep_n = '0;
                    if (!raw_s) begin
                        state_n = LOW;
                        cnt_n   = '0;
                    end else if (cnt == ST_LAST) begin
                        state_n = HIGH;
                        cnt_n   = '0;
                        level_n = 1'b1;
                        pulse_n = PULSE_RISE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (!raw_s) begin
                        rep_n = '0;
                        if (STABLE_TICKS == 1) begin
                            state_n = LOW;
                            cnt_n   = '0;
                            level_n = 1'b0;
                            pulse_n = PULSE_FALL;
                        end else begin
                            state_n = FALL_WAIT;
                            cnt_n   = CW'(1);
                        end
                    end else if (REPEAT_TICKS > 0) begin
                        // Auto-repeat fires independently of EDGE_MODE.
                        if (rep == REP_LAST) begin
                            pulse_n = 1'b1;
                            rep_n   = '0;
                        end else begin
                            rep_n = rep + RW'(1);
                        end
                    end
                end
                FALL_WAIT: begin
                    rep_n = '0;
                    if (raw_s) begin
                        // Bounce back: re-enter HIGH with a fresh repeat count.
                        state_n = HIGH;
                        cnt_n   = '0;
                    end else if (cnt == ST_LAST) begin
                        state_n = LOW;
                        cnt_n   = '0;
                        level_n = 1'b0;
                        pulse_n = PULSE_FALL;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = LOW;
                    cnt_n   = '0;
                    rep_n   = '0;
                end
            endcase
        end
    end

    assign busy = (state == RISE_WAIT) || (state == FALL_WAIT);
endmodule

module multi_switch_cleaner #(
    parameter int CHANNELS     = 4,
    parameter int TICK_DIV     = 4,
    parameter int STABLE_TICKS = 3,
    parameter int EDGE_MODE    = 0,
    parameter int REPEAT_TICKS = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] clean,
    output logic [CHANNELS-1:0] level,
    output logic                enable,
    output logic                busy
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PTERM = PW'(TICK_DIV - 1);

    logic [PW-1:0]       pcnt;
    logic [CHANNELS-1:0] raw_m, raw_s, busy_v;

    // Prescaler; enable is registered so it is glitch-free for the FSMs.
    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt   <= '0;
            enable <= 1'b0;
        end else begin
            enable <= (pcnt == PTERM);
            pcnt   <= (pcnt == PTERM) ? '0 : pcnt + PW'(1);
        end
    end

    // Two-flop synchroniser; only raw_s is used downstream.
    always_ff @(posedge clock) begin
        if (reset) begin
            raw_m <= '0;
            raw_s <= '0;
        end else begin
            raw_m <= raw;
            raw_s <= raw_m;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        msc_channel #(
            .STABLE_TICKS(STABLE_TICKS),
            .EDGE_MODE   (EDGE_MODE),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_ch (
            .clock(clock),
            .reset(reset),
            .tick (enable),
            .raw_s(raw_s[c]),
            .clean(clean[c]),
            .level(level[c]),
            .busy (busy_v[c])
        );
    end

    assign busy = |busy_v;
endmodule

// File: tb/tb_multi_switch_cleaner.sv
module tb_multi_switch_cleaner;
    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] raw_a, raw_b, raw_c, clean_a, clean_b, clean_c, level_a, level_b, level_c;
    logic [1:0] raw_d, clean_d, level_d;
    logic       en_a, en_b, en_c, en_d, busy_a, busy_b, busy_c, busy_d;

    always #5 clock = ~clock;

    // A: rise-only; B: both edges; C: rise + repeat 5; D: fastest corner.
    multi_switch_cleaner #(.CHANNELS(4), .TICK_DIV(4), .STABLE_TICKS(3), .EDGE_MODE(0), .REPEAT_TICKS(0))
        u_a (.clock(clock), .reset(reset), .raw(raw_a), .clean(clean_a), .level(level_a), .enable(en_a), .busy(busy_a));
    multi_switch_cleaner #(.CHANNELS(4), .TICK_DIV(4), .STABLE_TICKS(3), .EDGE_MODE(2), .REPEAT_TICKS(0))
        u_b (.clock(clock), .reset(reset), .raw(raw_b), .clean(clean_b), .level(level_b), .enable(en_b), .busy(busy_b));
    multi_switch_cleaner #(.CHANNELS(4), .TICK_DIV(4), .STABLE_TICKS(3), .EDGE_MODE(0), .REPEAT_TICKS(5))
        u_c (.clock(clock), .reset(reset), .raw(raw_c), .clean(clean_c), .level(level_c), .enable(en_c), .busy(busy_c));
    multi_switch_cleaner #(.CHANNELS(2), .TICK_DIV(1), .STABLE_TICKS(1), .EDGE_MODE(2), .REPEAT_TICKS(0))
        u_d (.clock(clock), .reset(reset), .raw(raw_d), .clean(clean_d), .level(level_d), .enable(en_d), .busy(busy_d));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pa[4], fa[4], pb[4], pd[2], fd[2];
    int qc[$];
    int enq[$];
    logic busy_seen;

    always @(posedge clock) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    always @(negedge clock) begin
        for (int c = 0; c < 4; c++) begin
            if (clean_a[c]) begin
                if (pa[c] == 0) fa[c] = cyc;
                pa[c]++;
            end
            if (clean_b[c]) pb[c]++;
            if (clean_c[c] && c == 2) qc.push_back(cyc);
        end
        for (int c = 0; c < 2; c++)
            if (clean_d[c]) begin
                if (pd[c] == 0) fd[c] = cyc;
                pd[c]++;
            end
        if (busy_a) busy_seen = 1'b1;
        if (en_a) enq.push_back(cyc);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < 4; c++) begin
            pa[c] = 0; fa[c] = 0; pb[c] = 0;
        end
        for (int c = 0; c < 2; c++) begin
            pd[c] = 0; fd[c] = 0;
        end
        busy_seen = 1'b0;
    endtask

    task automatic drive_b0(input logic v, input int n);
        raw_b[0] = v;
        repeat (n) step();
    endtask

    typedef struct {
        int   ch;
        int   hi;
        int   exp_pulses;
        logic exp_level;
    } vec_t;

    vec_t vt[4];
    int   n, others;

    initial begin
        vt[0] = '{ch: 0, hi: 40, exp_pulses: 1, exp_level: 1'b1};
        vt[1] = '{ch: 1, hi: 5,  exp_pulses: 0, exp_level: 1'b0};
        vt[2] = '{ch: 2, hi: 7,  exp_pulses: 0, exp_level: 1'b0};
        vt[3] = '{ch: 3, hi: 16, exp_pulses: 1, exp_level: 1'b1};

        reset = 1'b1;
        raw_a = '0; raw_b = '0; raw_c = '0; raw_d = '0;
        clear_counts();
        repeat (3) step();
        check("rst_a", int'({clean_a, level_a, en_a, busy_a}), 0);
        check("rst_b", int'({clean_b, level_b, en_b, busy_b}), 0);
        check("rst_c", int'({clean_c, level_c, en_c, busy_c}), 0);
        check("rst_d", int'({clean_d, level_d, en_d, busy_d}), 0);

        // Prescaler after release: enable at edges N+4, N+8, ...
        enq.delete();
        reset = 1'b0;
        n = cyc;
        repeat (17) step();
        check("en_count", enq.size(), 4);
        if (enq.size() >= 2) begin
            check("en_first", enq[0] - n, 4);
            check("en_period", enq[1] - enq[0], 4);
        end else begin
            check("en_seen", enq.size(), 4);
        end
        check("en_div1", int'(en_d), 1);

        // Table: single presses/glitches on instance A (rise-only).
        for (int i = 0; i < 4; i++) begin
            clear_counts();
            raw_a[vt[i].ch] = 1'b1;
            n = cyc;
            repeat (vt[i].hi) step();
            check($sformatf("v%0d_level", i), int'(level_a[vt[i].ch]), int'(vt[i].exp_level));
            check($sformatf("v%0d_pulses", i), pa[vt[i].ch], vt[i].exp_pulses);
            check($sformatf("v%0d_busy", i), int'(busy_seen), 1);
            if (vt[i].exp_pulses == 1)
                check_rng($sformatf("v%0d_latency", i), fa[vt[i].ch] - n - 1, 10, 13);
            raw_a[vt[i].ch] = 1'b0;
            repeat (24) step();
            check($sformatf("v%0d_pulses_rel", i), pa[vt[i].ch], vt[i].exp_pulses);
            check($sformatf("v%0d_level_rel", i), int'(level_a[vt[i].ch]), 0);
            others = 0;
            for (int c = 0; c < 4; c++) if (c != vt[i].ch) others += pa[c];
            check($sformatf("v%0d_others", i), others, 0);
        end

        // Bouncy press and release on B (both edges).
        clear_counts();
        drive_b0(1'b1, 3); drive_b0(1'b0, 3); drive_b0(1'b1, 2); drive_b0(1'b1, 30);
        check("bounce_press_pulses", pb[0], 1);
        check("bounce_press_level", int'(level_b[0]), 1);
        drive_b0(1'b0, 3); drive_b0(1'b1, 3); drive_b0(1'b0, 2); drive_b0(1'b0, 30);
        check("bounce_rel_pulses", pb[0], 2);
        check("bounce_rel_level", int'(level_b[0]), 0);
        check("bounce_others", pb[1] + pb[2] + pb[3], 0);

        // Auto-repeat on C ch2: accept then every 20 cycles, none after release.
        qc.delete();
        raw_c[2] = 1'b1;
        n = cyc;
        repeat (100) step();
        raw_c[2] = 1'b0;
        repeat (40) step();
        check("rep_count", qc.size(), 5);
        if (qc.size() > 0) check_rng("rep_first", qc[0] - n - 1, 10, 13);
        for (int i = 1; i < qc.size(); i++)
            check($sformatf("rep_gap%0d", i), qc[i] - qc[i-1], 20);
        check("rep_level_rel", int'(level_c[2]), 0);

        // TICK_DIV=1, STABLE_TICKS=1: accept two edges after sampling.
        clear_counts();
        raw_d[0] = 1'b1;
        n = cyc;
        repeat (6) step();
        check("fast_rise_at", fd[0] - n, 3);
        check("fast_level", int'(level_d[0]), 1);
        raw_d[0] = 1'b0;
        repeat (6) step();
        check("fast_both_pulses", pd[0], 2);
        check("fast_level_rel", int'(level_d[0]), 0);

        // Reset while ch0 is HIGH with raw still 1: must re-qualify.
        clear_counts();
        raw_a[0] = 1'b1;
        repeat (30) step();
        check("rr_level_pre", int'(level_a[0]), 1);
        reset = 1'b1;
        step();
        check("rr_level_in_reset", int'(level_a[0]), 0);
        repeat (5) step();
        reset = 1'b0;
        clear_counts();
        n = cyc;
        repeat (20) step();
        check("rr_pulses", pa[0], 1);
        check_rng("rr_latency", fa[0] - n - 1, 10, 13);
        check("rr_level", int'(level_a[0]), 1);
        raw_a[0] = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
